// File: rtl/fb_pkg.sv
// fb_pkg: shared defaults, pixel/coordinate types and clear-FSM states for the framebuffer writer
package fb_pkg;
  localparam int FB_SCREEN_W = 320;
  localparam int FB_SCREEN_H = 240;
  localparam int FB_COORD_W  = 16;
  localparam int FB_COLOR_W  = 12;
  localparam int FB_ADDR_W   = 17;
  typedef logic signed [FB_COORD_W-1:0] coord_t;
  typedef logic [FB_COLOR_W-1:0] color_t;
  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} fb_state_t;
endpackage

// File: rtl/fb_clip_addr.sv
// fb_clip_addr: two-stage clip + linear-address pipeline feeding the framebuffer write port
// Ports:
//   i_clk, i_rst                  clock, async active-high reset
//   i_valid, i_x, i_y, i_color    accepted point (signed coordinates)
//   i_ovr_we/addr/data            fill write, loaded into stage 2 when no point write is due
//   o_clip                        combinational: accepted point lies off-screen
//   o_s1_valid                    stage 1 occupied (FB_CLEAR_EN builds only)
//   o_we, o_addr, o_data          registered framebuffer write port; addr/data hold when idle
module fb_clip_addr import fb_pkg::*; #(
  parameter int SCREEN_W = FB_SCREEN_W,
  parameter int SCREEN_H = FB_SCREEN_H,
  parameter int COORD_W  = FB_COORD_W,
  parameter int COLOR_W  = FB_COLOR_W,
  parameter int ADDR_W   = FB_ADDR_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic signed [COORD_W-1:0] i_x,
  input  logic signed [COORD_W-1:0] i_y,
  input  logic [COLOR_W-1:0]        i_color,
  input  logic                      i_ovr_we,
  input  logic [ADDR_W-1:0]         i_ovr_addr,
  input  logic [COLOR_W-1:0]        i_ovr_data,
  output logic                      o_clip,
`ifdef FB_CLEAR_EN
  output logic                      o_s1_valid,
`endif
  output logic                      o_we,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [COLOR_W-1:0]        o_data
);
  logic in_range, s1_write;
  logic s1_valid_q, s1_in_q, we_q, we_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d, addr_q, addr_d;
  logic [COLOR_W-1:0] s1_color_q, data_q, data_d;
  assign in_range = int'(i_x) >= 0 && int'(i_x) < SCREEN_W && int'(i_y) >= 0 && int'(i_y) < SCREEN_H;
  assign s1_addr_d = ADDR_W'(int'(i_y) * SCREEN_W + int'(i_x));
  assign o_clip = i_valid & ~in_range;
  assign s1_write = s1_valid_q & s1_in_q;
  // point writes win; the fill path only drives stage 2 when no point is in flight
  assign we_d = s1_write | i_ovr_we;
  assign addr_d = s1_write ? s1_addr_q : i_ovr_we ? i_ovr_addr : addr_q;
  assign data_d = s1_write ? s1_color_q : i_ovr_we ? i_ovr_data : data_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_in_q <= 1'b0;
      s1_addr_q <= '0;
      s1_color_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      s1_valid_q <= i_valid;
      s1_in_q <= in_range;
      s1_addr_q <= s1_addr_d;
      s1_color_q <= i_color;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
`ifdef FB_CLEAR_EN
  assign o_s1_valid = s1_valid_q;
`endif
  assign o_we = we_q;
  assign o_addr = addr_q;
  assign o_data = data_q;
endmodule

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: clips screen-space points and writes them to a framebuffer BRAM, optional frame clear
// Ports:
//   i_clk, i_rst                         clock, async active-high reset
//   i_pt_valid/o_pt_ready                point handshake; i_pt_x, i_pt_y signed, i_pt_color
//   i_frame_start                        new-frame pulse (resets clip count; starts clear when enabled)
//   o_fb_we, o_fb_addr, o_fb_data        single BRAM write port
//   o_busy                               drain/clear in progress
//   o_clip_cnt                           saturating count of points discarded this frame
// Build option: define FB_CLEAR_EN to add the DRAIN/CLEAR sweep writing CLEAR_COLOR on each frame start.
module framebuffer_writer import fb_pkg::*; #(
  parameter int SCREEN_W = FB_SCREEN_W,
  parameter int SCREEN_H = FB_SCREEN_H,
  parameter int COORD_W  = FB_COORD_W,
  parameter int COLOR_W  = FB_COLOR_W,
  parameter int ADDR_W   = FB_ADDR_W,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_pt_valid,
  output logic                      o_pt_ready,
  input  logic signed [COORD_W-1:0] i_pt_x,
  input  logic signed [COORD_W-1:0] i_pt_y,
  input  logic [COLOR_W-1:0]        i_pt_color,
  input  logic                      i_frame_start,
  output logic                      o_fb_we,
  output logic [ADDR_W-1:0]         o_fb_addr,
  output logic [COLOR_W-1:0]        o_fb_data,
  output logic                      o_busy,
  output logic [15:0]               o_clip_cnt
);
  logic accept, clip, clip_clr, ovr_we, rdy_q;
  logic [ADDR_W-1:0] ovr_addr;
  logic [15:0] clip_cnt_q, clip_cnt_d;
  assign accept = i_pt_valid & o_pt_ready;
  // held low through reset, first raised by the edge after release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rdy_q <= 1'b0;
    else rdy_q <= 1'b1;
  end
`ifdef FB_CLEAR_EN
  localparam int NPIX = SCREEN_W * SCREEN_H;
  logic s1_valid;
  fb_state_t state_q, state_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // the clear address lives in the output register itself: each fill write is o_fb_addr+1
  always_comb begin
    state_d = state_q;
    ovr_we = 1'b0;
    ovr_addr = '0;
    case (state_q)
      ST_IDLE: state_d = i_frame_start ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        state_d = s1_valid ? ST_DRAIN : ST_CLEAR;
        ovr_we = ~s1_valid;
      end
      ST_CLEAR: begin
        ovr_we = i_frame_start || o_fb_addr != ADDR_W'(NPIX - 1);
        state_d = ovr_we ? ST_CLEAR : ST_IDLE;
        ovr_addr = i_frame_start ? '0 : o_fb_addr + ADDR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign clip_clr = i_frame_start && state_q == ST_IDLE;
  assign o_pt_ready = rdy_q && state_q == ST_IDLE;
  assign o_busy = state_q != ST_IDLE;
`else
  assign ovr_we = 1'b0;
  assign ovr_addr = '0;
  assign clip_clr = i_frame_start;
  assign o_pt_ready = rdy_q;
  assign o_busy = 1'b0;
`endif
  assign clip_cnt_d = clip_clr ? '0 : (clip && clip_cnt_q != 16'hFFFF) ? clip_cnt_q + 16'd1 : clip_cnt_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) clip_cnt_q <= '0;
    else clip_cnt_q <= clip_cnt_d;
  end
  assign o_clip_cnt = clip_cnt_q;
  fb_clip_addr #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .COORD_W(COORD_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W)
  ) u_clip (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(accept),
    .i_x(i_pt_x),
    .i_y(i_pt_y),
    .i_color(i_pt_color),
    .i_ovr_we(ovr_we),
    .i_ovr_addr(ovr_addr),
    .i_ovr_data(CLEAR_COLOR),
    .o_clip(clip),
`ifdef FB_CLEAR_EN
    .o_s1_valid(s1_valid),
`endif
    .o_we(o_fb_we),
    .o_addr(o_fb_addr),
    .o_data(o_fb_data)
  );
endmodule

// File: doc/framebuffer_writer.md
FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, horizontal resolution in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 240, vertical resolution in pixels.
REQ-003 SHALL have parameter COORD_W, default 16, signed screen-coordinate width.
REQ-004 SHALL have parameter COLOR_W, default 12, pixel colour width.
REQ-005 SHALL have parameter ADDR_W, default 17, framebuffer address width, at least clog2(SCREEN_W*SCREEN_H).
REQ-006 SHALL have parameter CLEAR_COLOR, default 0, fill value written during a clear.
REQ-007 SHALL have port i_clk  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port i_pt_valid  input  1  screen-space point offered.
REQ-010 SHALL have port o_pt_ready  output  1  point accepted when valid and ready are both high.
REQ-011 SHALL have ports i_pt_x and i_pt_y  input  COORD_W each  signed screen coordinates from the geometry engine.
REQ-012 SHALL have port i_pt_color  input  COLOR_W  pixel colour.
REQ-013 SHALL have port i_frame_start  input  1  single-cycle new-frame pulse.
REQ-014 SHALL have ports o_fb_we (1), o_fb_addr (ADDR_W) and o_fb_data (COLOR_W)  outputs  single write port to framebuffer BRAM, which always accepts.
REQ-015 SHALL have port o_busy  output  1  clear or drain in progress.
REQ-016 SHALL have port o_clip_cnt  output  16  points discarded this frame.

Function
REQ-017 Accepted point SHALL be clipped: write only if 0<=x<SCREEN_W and 0<=y<SCREEN_H, using signed compares.
REQ-018 In-range point accepted in cycle N SHALL produce o_fb_we=1 in cycle N+2, with o_fb_addr=y*SCREEN_W+x and o_fb_data=colour.
REQ-019 Pipeline SHALL sustain one point per cycle with no bubbles, and SHALL preserve write order.
REQ-020 Clipped point SHALL produce no write and SHALL increment o_clip_cnt, saturating at 0xFFFF.
REQ-021 o_fb_we SHALL be 0 in every cycle without a valid write. o_fb_addr and o_fb_data SHALL hold their last values.
REQ-022 FSM states SHALL be IDLE, DRAIN and CLEAR.
REQ-023 In IDLE, o_pt_ready SHALL be 1.
REQ-024 i_frame_start in IDLE SHALL clear o_clip_cnt and SHALL move to DRAIN next cycle.
REQ-025 A point handshaken in the same cycle as i_frame_start SHALL be accepted and written.
REQ-026 In DRAIN, o_pt_ready SHALL be 0. When the pipeline is empty (at most 2 cycles), the FSM SHALL move to CLEAR.
REQ-027 CLEAR SHALL write CLEAR_COLOR to addresses 0..SCREEN_W*SCREEN_H-1, one per cycle in ascending order, then return to IDLE. o_pt_ready SHALL be 0 throughout CLEAR.
REQ-028 i_frame_start during CLEAR SHALL restart the sweep at address 0 next cycle.
REQ-029 i_frame_start during DRAIN SHALL be ignored.
REQ-030 o_busy SHALL be 1 exactly when the state is DRAIN or CLEAR.

Reset
REQ-031 While i_rst=1, the block SHALL hold: state IDLE, pipeline empty, o_fb_we=0, o_fb_addr=0, o_fb_data=0, o_clip_cnt=0, o_busy=0, o_pt_ready=0.
REQ-032 o_pt_ready SHALL be 1 on the first edge after i_rst deasserts.
REQ-033 Reset mid-clear or mid-pipeline SHALL abort with no further writes.

Configuration
REQ-034 Macro FB_CLEAR_EN defined: DRAIN/CLEAR behaviour as above.
REQ-035 Macro FB_CLEAR_EN undefined: no DRAIN/CLEAR logic. i_frame_start SHALL only clear o_clip_cnt. o_pt_ready SHALL be 1 whenever not in reset. o_busy SHALL be tied 0.

Structure
REQ-036 Package fb_pkg SHALL hold SCREEN_W/SCREEN_H defaults, coord_t, color_t, fb_addr_t and the FSM state enum fb_state_t.
REQ-037 Clip and address computation SHALL be in sub-module fb_clip_addr: 2-stage pipeline carrying valid, in-range, address and colour.

Verification (SCREEN_W=320, SCREEN_H=240)
REQ-038 Point (10,2,0xABC) accepted at cycle N -> o_fb_we=1 at N+2, addr=650, data=0xABC.
REQ-039 Points (-1,5), (320,0), (0,240), (319,239) -> single write at addr 76799; o_clip_cnt=3.
REQ-040 Four points on consecutive cycles -> four consecutive writes in order; o_pt_ready stays 1.
REQ-041 FB_CLEAR_EN, i_frame_start with one point in flight -> point written first, then 76800 writes of CLEAR_COLOR at addrs 0..76799; o_busy high throughout; o_pt_ready returns to 1 after; o_clip_cnt=0.
REQ-042 i_frame_start when clear is at addr 1000 -> next clear write at addr 0.
REQ-043 i_rst asserted mid-clear -> o_fb_we=0 immediately, all outputs 0; ready=1 one cycle after release; no further writes.
